// File: rtl/booth_mult_sched_if.sv
// booth_mult_sched_if
//   Request/response bundle between NREQ requesters and the shared Booth
//   multiplier scheduler.
//   Request side (per requester i, packed):
//     req_valid[i], req_ready[i], req_m[i*N +: N], req_q[i*N +: N]
//   Response side (single channel):
//     rsp_valid, rsp_ready, rsp_id, rsp_p, rsp_err
//   Modports:
//     master - requester/consumer side (drives requests, rsp_ready)
//     slave  - scheduler side (drives req_ready and the response)
interface booth_mult_sched_if #(
    parameter  int NB   = 2,
    parameter  int NREQ = 4,
    localparam int N    = 2**NB,
    localparam int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_m;
    logic [NREQ*N-1:0] req_q;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*N-1:0]    rsp_p;
    logic              rsp_err;

    modport master (
        output req_valid, req_m, req_q, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
    );

    modport slave (
        input  req_valid, req_m, req_q, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
    );
endinterface

// File: rtl/booth_mult_sched.sv
// booth_mult_sched
//   Round-robin scheduler sharing one external sequential Booth multiplier
//   core (N-bit signed operands, 2N-bit product, done pulse) among NREQ
//   requesters. One job is in flight at a time:
//     IDLE -> accept a request (round robin)
//     LOAD -> present latched operands to the core while it is still held
//     RUN  -> core steps; wait for core_done or watchdog expiry
//     RESP -> hold the response until rsp_ready
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     bus (slave)     request channels in, response channel out
//     core_ld         core load/hold, low only in RUN (core reset = ~core_ld)
//     core_m, core_q  operands to the core, stable from LOAD through RUN
//     core_done       core done pulse, only observed in RUN
//     core_p          core product {A,Q}
//     busy            high whenever not in IDLE
module booth_mult_sched #(
    parameter  int NB      = 2,
    parameter  int NREQ    = 4,
    parameter  int TMO_CYC = 16,
    localparam int N       = 2**NB,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    booth_mult_sched_if.slave bus,
    output logic              core_ld,
    output logic [N-1:0]      core_m,
    output logic [N-1:0]      core_q,
    input  logic              core_done,
    input  logic [2*N-1:0]    core_p,
    output logic              busy
);

    // Watchdog must be able to hold TMO_CYC-1 without wrapping.
    localparam int WDW = $clog2(TMO_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // The job currently owned by the core; id doubles as rsp_id.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   m;
        logic [N-1:0]   q;
    } job_t;

    state_t         state, nstate;
    logic [IDW-1:0] rr_ptr;
    job_t           job;
    logic [WDW-1:0] wd;
    logic [2*N-1:0] rsp_p_r;
    logic           rsp_err_r;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW:0]   cand;
    logic           grant_ok;
    logic           tmo_hit;

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last winner. cand is one
    // bit wider than an id so rr_ptr+k never wraps before the modulo fold,
    // which keeps this correct for non-power-of-two NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && bus.req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    // A grant is only offered in IDLE; valid is already implied by found,
    // so a grant is also an accept. Gated by rst so nothing is offered
    // while the block is being cleared.
    assign grant_ok      = (state == IDLE) && found && !rst;
    assign bus.req_ready = grant_ok ? (NREQ'(1) << win) : '0;

    assign tmo_hit = (wd == WDW'(TMO_CYC - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (grant_ok) nstate = LOAD;
            LOAD: nstate = RUN;
            // done and timeout leave RUN the same way; which one wins is
            // decided in the datapath below.
            RUN:  if (core_done || tmo_hit) nstate = RESP;
            RESP: if (bus.rsp_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: arbitration pointer, latched job, watchdog, response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= IDW'(NREQ - 1);
            job       <= '0;
            wd        <= '0;
            rsp_p_r   <= '0;
            rsp_err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        rr_ptr <= win;
                        job.id <= win;
                        job.m  <= bus.req_m[win*N +: N];
                        job.q  <= bus.req_q[win*N +: N];
                    end
                end
                LOAD: wd <= '0;
                RUN: begin
                    wd <= wd + 1'b1;
                    // A done pulse in the final watchdog cycle still
                    // delivers the product.
                    if (core_done) begin
                        rsp_p_r   <= core_p;
                        rsp_err_r <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_p_r   <= '0;
                        rsp_err_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. core_ld is high in every state but RUN so the core sits in
    // load/hold whenever it is not actively computing our job, including
    // straight after a reset that aborted a job mid-run.
    // ------------------------------------------------------------------
    assign core_ld       = (state != RUN);
    assign core_m        = job.m;
    assign core_q        = job.q;
    assign busy          = (state != IDLE);

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = job.id;
    assign bus.rsp_p     = rsp_p_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_booth_mult_sched.sv
// tb_booth_mult_sched
//   Scoreboard bench: a behavioural radix-2 Booth core drives the core
//   port; accepted requests push their expected response (id, signed
//   product or timeout error, latency) and each response handshake pops
//   and compares.
module tb_booth_mult_sched;
    localparam int NB      = 2;
    localparam int NREQ    = 4;
    localparam int TMO_CYC = 16;
    localparam int N       = 2**NB;
    localparam int IDW     = $clog2(NREQ);

    logic           clk = 1'b0;
    logic           rst;
    logic           core_ld;
    logic [N-1:0]   core_m, core_q;
    logic           core_done;
    logic [2*N-1:0] core_p;
    logic           busy;

    booth_mult_sched_if #(.NB(NB), .NREQ(NREQ)) bus ();

    booth_mult_sched #(.NB(NB), .NREQ(NREQ), .TMO_CYC(TMO_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_ld   (core_ld),
        .core_m    (core_m),
        .core_q    (core_q),
        .core_done (core_done),
        .core_p    (core_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural Booth core ----------------
    logic         kill = 1'b0;   // suppress done to exercise the watchdog
    logic [N:0]   ca, cadd;
    logic [N-1:0] cq, cm;
    logic         cq1;
    int           ccnt;

    assign cadd = ({cq[0], cq1} == 2'b01) ? ca + {cm[N-1], cm} :
                  ({cq[0], cq1} == 2'b10) ? ca - {cm[N-1], cm} : ca;

    always @(posedge clk) begin
        if (core_ld) begin
            ca   <= '0;
            cq   <= core_q;
            cm   <= core_m;
            cq1  <= 1'b0;
            ccnt <= 0;
        end else if (ccnt < N) begin
            ca   <= {cadd[N], cadd[N:1]};
            cq   <= {cadd[0], cq[N-1:1]};
            cq1  <= cq[0];
            ccnt <= ccnt + 1;
        end else begin
            ccnt <= N + 1;
        end
    end

    assign core_done = !kill && !core_ld && (ccnt == N);
    assign core_p    = {ca[N-1:0], cq};

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] sa, sb;
        sa = {{N{a[N-1]}}, a};
        sb = {{N{b[N-1]}}, b};
        return sa * sb;
    endfunction

    typedef struct {
        logic [IDW-1:0] id;
        logic [2*N-1:0] p;
        logic           err;
        int             acc;
        int             lat;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] om[NREQ];
    logic [N-1:0] oq[NREQ];
    int           cyc = 0;
    int           n_acc = 0;
    int           last_win = -1;
    int           exp_ptr = NREQ - 1;
    int           last_hs = 0;
    bit           have_hs = 0;
    bit           resume_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge.
    initial begin : mon
        int             ew, rise;
        exp_t           e;
        bit             pv, prdy;
        logic [IDW-1:0] pid;
        logic [2*N-1:0] pp;
        logic           perr;
        rise = 0; pv = 0; prdy = 1; pid = '0; pp = '0; perr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ptr = NREQ - 1;
                have_hs = 0;
                pv      = 0;
                prdy    = 1;
            end else begin
                chk("rdy_onehot", $onehot0(bus.req_ready), 1);
                if (busy) chk("rdy_busy", bus.req_ready, 0);
                if (bus.req_ready != 0) begin
                    ew = -1;
                    for (int k = 1; k <= NREQ; k++)
                        if (ew < 0 && bus.req_valid[(exp_ptr + k) % NREQ])
                            ew = (exp_ptr + k) % NREQ;
                    chk("grant", bus.req_ready, (ew < 0) ? 64'd0 : (64'd1 << ew));
                    if (ew >= 0) begin
                        e.id  = IDW'(ew);
                        e.err = kill;
                        e.p   = kill ? '0 : prod(om[ew], oq[ew]);
                        e.acc = cyc;
                        e.lat = kill ? TMO_CYC + 2 : N + 3;
                        sb.push_back(e);
                        exp_ptr  = ew;
                        last_win = ew;
                        n_acc++;
                        if (resume_en && have_hs) chk("resume_cyc", cyc, last_hs + 1);
                    end
                end
                if (pv && !prdy) begin
                    chk("hold_v", bus.rsp_valid, 1);
                    chk("hold_id", bus.rsp_id, pid);
                    chk("hold_p", bus.rsp_p, pp);
                    chk("hold_err", bus.rsp_err, perr);
                end
                if (bus.rsp_valid && !pv) rise = cyc;
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", bus.rsp_id, e.id);
                        chk("rsp_p", bus.rsp_p, e.p);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("rsp_lat", rise - e.acc, e.lat);
                    end
                    last_hs = cyc;
                    have_hs = 1;
                end
                pv   = bus.rsp_valid;
                prdy = bus.rsp_ready;
                pid  = bus.rsp_id;
                pp   = bus.rsp_p;
                perr = bus.rsp_err;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+#1) ----------------
    task automatic set_op(input int id, input logic [N-1:0] m, input logic [N-1:0] q);
        om[id] = m;
        oq[id] = q;
        bus.req_m[id*N +: N] = m;
        bus.req_q[id*N +: N] = q;
    endtask

    task automatic wait_acc(input int prev);
        int n = 0;
        while (n_acc <= prev && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n_acc <= prev) chk("acc_timeout", 0, 1);
    endtask

    task automatic issue(input int id, input logic [N-1:0] m, input logic [N-1:0] q);
        int prev;
        prev = n_acc;
        set_op(id, m, q);
        bus.req_valid[id] = 1'b1;
        wait_acc(prev);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int prev;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_m     = '0;
        bus.req_q     = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            om[i] = '0;
            oq[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_p", bus.rsp_p, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_ld", core_ld, 1);
        chk("rst_core_m", core_m, 0);
        chk("rst_core_q", core_q, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // single request and operand corners
        issue(0, N'(3), N'(-2));
        issue(1, N'(-8), N'(-8));
        issue(2, N'(7), N'(7));
        issue(3, N'(-8), N'(7));
        for (int i = 0; i < 6; i++)
            issue(int'($urandom_range(NREQ - 1, 0)), N'($urandom), N'($urandom));
        drain();

        // fairness: all requesters valid from reset
        rst = 1'b1;
        set_op(0, N'(3), N'(5));
        set_op(1, N'(-4), N'(6));
        set_op(2, N'(-8), N'(-8));
        set_op(3, N'(7), N'(-1));
        bus.req_valid = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        resume_en = 1;
        for (int g = 0; g < 8; g++) begin
            prev = n_acc;
            wait_acc(prev);
            chk("fair_order", last_win, g % NREQ);
        end
        bus.req_valid = '0;
        resume_en = 0;
        drain();

        // backpressure: response held for 10 cycles, req 2 waits
        bus.rsp_ready = 1'b0;
        issue(1, N'(6), N'(-7));
        resume_en = 1;
        set_op(2, N'(-3), N'(5));
        bus.req_valid[2] = 1'b1;
        for (int n = 0; n < 50 && !bus.rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        prev = n_acc;
        bus.rsp_ready = 1'b1;
        wait_acc(prev);
        chk("bp_next_id", last_win, 2);
        bus.req_valid[2] = 1'b0;
        resume_en = 0;
        drain();

        // watchdog: no done pulse, then a normal job
        kill = 1'b1;
        issue(3, N'(5), N'(-3));
        drain();
        kill = 1'b0;
        issue(0, N'(-5), N'(6));
        drain();

        // reset in the middle of RUN
        issue(2, N'(4), N'(-6));
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!core_ld) break;
        end
        chk("mr_in_run", core_ld, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mr_busy", busy, 0);
        chk("mr_rsp_valid", bus.rsp_valid, 0);
        chk("mr_core_ld", core_ld, 1);
        @(posedge clk); #1;
        set_op(0, N'(-7), N'(3));
        prev = n_acc;
        bus.req_valid = '1;
        wait_acc(prev);
        bus.req_valid = '0;
        chk("mr_first_win", last_win, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_mult_sched.md
Name: booth_mult_sched

Overview:
- Round-robin scheduler that shares one sequential Booth multiplier core (N-bit signed operands, 2N-bit product, one shift/add step per clock, single-cycle done pulse) among NREQ requesters.
- Arbitrates valid/ready requests, loads the core, waits for its done pulse and captures the product.
- Returns the product with the requester ID over a valid/ready response channel.
- Includes a watchdog that converts a missing done pulse into an error response.

Parameters:
- NB, 2, log2 of operand width; N = 2**NB (localparam).
- NREQ, 4, number of requesters (>=2); IDW = $clog2(NREQ) (localparam).
- TMO_CYC, 16, maximum cycles spent in RUN before a timeout; must be > N+1.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_m  in  NREQ*N  packed multiplicands; requester i uses bits [i*N +: N].
- req_q  in  NREQ*N  packed multipliers, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_p  out  2N  signed product (two's complement).
- rsp_err  out  1  response is a watchdog timeout.
- core_ld  out  1  core load/hold; the integrator drives core reset = ~core_ld.
- core_m  out  N  multiplicand to core.
- core_q  out  N  multiplier to core.
- core_done  in  1  core done pulse.
- core_p  in  2N  core product {A,Q}.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States:
  - IDLE: core_ld=1.
  - LOAD: core_ld=1.
  - RUN: core_ld=0.
  - RESP: core_ld=1.
  - core_ld is low only in RUN, so the core never free-runs.
- Reset: state=IDLE, rr_ptr=NREQ-1, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_p=0, req_ready=0, busy=0, core_ld=1, operand regs=0, watchdog=0.
- Reset mid-operation aborts the transaction with no response; the core is re-held via core_ld=1.
- Arbitration (IDLE only):
  - Search order is rr_ptr+1, rr_ptr+2, … mod NREQ; the first requester with valid=1 wins.
  - req_ready[winner] is combinational and high in that cycle only. req_ready is 0 in all other states.
  - On accept (valid&ready): latch that requester's m, q and id; rr_ptr<=winner; go to LOAD.
  - rr_ptr changes only on accept.
- LOAD (1 cycle): core_m/core_q driven from the latched regs (held stable through RUN); next state RUN; watchdog cleared.
- RUN:
  - Watchdog increments each cycle.
  - If core_done=1: rsp_p<=core_p, rsp_err<=0, go to RESP.
  - Else if watchdog reaches TMO_CYC-1: rsp_p<=0, rsp_err<=1, go to RESP.
  - If done and timeout coincide, done wins.
- core_done is ignored outside RUN.
- Latency with the accept at cycle T:
  - LOAD at T+1.
  - RUN from T+2 for N+1 cycles; core_done is seen in the last of them.
  - rsp_valid rises at T+N+3 (T+7 for N=4).
- RESP:
  - rsp_valid=1; rsp_id/rsp_p/rsp_err are stable until the handshake.
  - On rsp_valid&rsp_ready, go to IDLE with rsp_valid=0 next cycle.
  - The earliest next accept is the cycle after the response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely; requests wait, and no request is accepted while busy.
- Requests may drop valid before being accepted without side effects. The operands sampled are those present in the accept cycle.
- Arithmetic: signed N x N -> 2N, exact for all inputs including -2^(N-1) * -2^(N-1).

Test Plan:
- Single request: req 0 with m=3, q=-2 (4'hE), N=4 -> accept at T, rsp_valid at T+7, rsp_id=0, rsp_p=8'hFA, rsp_err=0.
- Corner operand: m=-8, q=-8 -> rsp_p=8'h40; m=7, q=7 -> 8'h31; m=-8, q=7 -> 8'hC8.
- Fairness: all 4 requesters hold valid continuously from reset -> grants in order 0,1,2,3,0,…; each response carries the matching id and product.
- Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid/id/p held constant, no req_ready asserted; accept resumes the cycle after the handshake.
- Watchdog: core_done tied 0 -> after 16 RUN cycles, rsp_valid=1, rsp_err=1, rsp_p=0; the scheduler then returns to IDLE and serves the next request.
- Mid-run reset: assert rst for 1 cycle during RUN -> next cycle IDLE, rsp_valid=0, core_ld=1, rr_ptr=3; the next request from requester 0 completes correctly.
